// File: rtl/hilo_mdu_ctrl.sv
// HI/LO register file with a 1-cycle multiplier and a 32-cycle restoring divider.
// The pipeline is stalled through MDU_Busy while a multiply or divide is in flight.
module hilo_mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EXE_MDUOp,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    input  logic        EXE_Flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        MDU_Busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        is_signed;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic        op_mul;
    logic        op_div;
    logic        op_mthi;
    logic        op_mtlo;
    logic        op_signed;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [32:0] r_sh;
    logic [32:0] diff;
    logic [63:0] acc_nxt;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign op_mul    = (EXE_MDUOp == 3'b001) || (EXE_MDUOp == 3'b010);
    assign op_div    = (EXE_MDUOp == 3'b011) || (EXE_MDUOp == 3'b100);
    assign op_mthi   = (EXE_MDUOp == 3'b101);
    assign op_mtlo   = (EXE_MDUOp == 3'b110);
    assign op_signed = (EXE_MDUOp == 3'b001) || (EXE_MDUOp == 3'b011);

    assign mag_a_in = (op_signed && EXE_BusA[31]) ? -EXE_BusA : EXE_BusA;
    assign mag_b    = (is_signed && op_b[31]) ? -op_b : op_b;

    // Sign-extending to 64 bits makes one multiplier serve both signednesses.
    assign ext_a = {{32{is_signed & op_a[31]}}, op_a};
    assign ext_b = {{32{is_signed & op_b[31]}}, op_b};
    assign prod  = ext_a * ext_b;

    // acc holds {partial remainder, dividend bits / quotient bits}.
    assign r_sh    = acc[63:31];
    assign diff    = r_sh - {1'b0, mag_b};
    assign acc_nxt = diff[32] ? {r_sh[31:0], acc[30:0], 1'b0}
                              : {diff[31:0], acc[30:0], 1'b1};

    assign neg_q = is_signed & (op_a[31] ^ op_b[31]);
    assign neg_r = is_signed & op_a[31];
    assign q_fix = neg_q ? -acc_nxt[31:0] : acc_nxt[31:0];
    assign r_fix = neg_r ? -acc_nxt[63:32] : acc_nxt[63:32];

    assign MDU_Busy = !EXE_Flush &&
                      ((state == IDLE && (op_mul || op_div)) ||
                       state == MUL || state == DIV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            HI        <= 32'h0;
            LO        <= 32'h0;
            cnt       <= 5'd0;
            op_a      <= 32'h0;
            op_b      <= 32'h0;
            is_signed <= 1'b0;
            acc       <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (!EXE_Flush) begin
                        unique case (1'b1)
                            op_mul: begin
                                op_a      <= EXE_BusA;
                                op_b      <= EXE_BusB;
                                is_signed <= op_signed;
                                state     <= MUL;
                            end
                            op_div: begin
                                op_a      <= EXE_BusA;
                                op_b      <= EXE_BusB;
                                is_signed <= op_signed;
                                cnt       <= 5'd0;
                                acc       <= {32'h0, mag_a_in};
                                state     <= (EXE_BusB != 32'h0) ? DIV : DONE;
                            end
                            op_mthi: HI <= EXE_BusA;
                            op_mtlo: LO <= EXE_BusA;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (EXE_Flush) begin
                        state <= IDLE;
                    end else begin
                        HI    <= prod[63:32];
                        LO    <= prod[31:0];
                        state <= DONE;
                    end
                end
                DIV: begin
                    if (EXE_Flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            LO    <= q_fix;
                            HI    <= r_fix;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: each busy run is matched against a
// queued expectation of its length and the HI/LO values when it ends.
module tb_hilo_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  EXE_MDUOp = 3'b000;
    logic [31:0] EXE_BusA = 32'h0;
    logic [31:0] EXE_BusB = 32'h0;
    logic        EXE_Flush = 1'b0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        MDU_Busy;

    hilo_mdu_ctrl dut (
        .clk(clk),
        .rst(rst),
        .EXE_MDUOp(EXE_MDUOp),
        .EXE_BusA(EXE_BusA),
        .EXE_BusB(EXE_BusB),
        .EXE_Flush(EXE_Flush),
        .HI(HI),
        .LO(LO),
        .MDU_Busy(MDU_Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Monitor: a busy run ends when MDU_Busy falls.
    int   run = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (MDU_Busy === 1'b1) begin
            run++;
        end else begin
            if (prev_busy === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_busy_run: len=%0d", run);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_len"}, 32'(run), 32'(e.len));
                    chk({e.name, "_hi"}, HI, e.hi);
                    chk({e.name, "_lo"}, LO, e.lo);
                end
            end
            run = 0;
        end
        prev_busy = MDU_Busy;
    end

    task automatic expect_run(string nm, int len, logic [31:0] hi, logic [31:0] lo);
        exp_t e;
        e.name = nm;
        e.len  = len;
        e.hi   = hi;
        e.lo   = lo;
        sbq.push_back(e);
    endtask

    task automatic md(string nm, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                      int len, logic [31:0] hi, logic [31:0] lo);
        int n;
        expect_run(nm, len, hi, lo);
        EXE_MDUOp = op;
        EXE_BusA  = a;
        EXE_BusB  = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (MDU_Busy === 1'b1 && n < 100);
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", nm, MDU_Busy, n);
        end
        @(posedge clk);
        #1;
        EXE_MDUOp = 3'b000;
    endtask

    task automatic mt(string nm, logic [2:0] op, logic [31:0] a, logic flush,
                      logic [31:0] hi, logic [31:0] lo);
        EXE_MDUOp = op;
        EXE_BusA  = a;
        EXE_Flush = flush;
        @(negedge clk);
        chk({nm, "_busy"}, 32'(MDU_Busy), 32'h0);
        @(posedge clk);
        #1;
        EXE_MDUOp = 3'b000;
        EXE_Flush = 1'b0;
        chk({nm, "_hi"}, HI, hi);
        chk({nm, "_lo"}, LO, lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        @(negedge clk);
        chk("rst_busy", 32'(MDU_Busy), 32'h0);
        @(posedge clk);
        #1;

        md("mult", 3'b001, 32'hFFFFFFFF, 32'h2, 2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        md("multu", 3'b010, 32'hFFFFFFFF, 32'h2, 2, 32'h00000001, 32'hFFFFFFFE);
        md("div_m7_2", 3'b011, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md("divu_100_7", 3'b100, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        md("divu_max_10", 3'b100, 32'hFFFFFFFF, 32'd10, 33, 32'd5, 32'h19999999);
        md("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);

        mt("mthi", 3'b101, 32'h12345678, 1'b0, 32'h12345678, 32'h80000000);
        md("div0", 3'b011, 32'd5, 32'd0, 1, 32'h12345678, 32'h80000000);
        mt("op111", 3'b111, 32'hDEADBEEF, 1'b0, 32'h12345678, 32'h80000000);
        mt("flush_mtlo", 3'b110, 32'hCAFEF00D, 1'b1, 32'h12345678, 32'h80000000);
        mt("flush_mult", 3'b001, 32'd3, 1'b1, 32'h12345678, 32'h80000000);

        // Abort a divide at iteration 10.
        expect_run("div_flush", 11, 32'h12345678, 32'h80000000);
        EXE_MDUOp = 3'b011;
        EXE_BusA  = 32'd100;
        EXE_BusB  = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        EXE_Flush = 1'b1;
        @(posedge clk);
        #1;
        EXE_Flush = 1'b0;
        EXE_MDUOp = 3'b000;
        md("multu_3_5", 3'b010, 32'd3, 32'd5, 2, 32'h0, 32'd15);

        // Reset in the middle of a divide.
        expect_run("div_rst", 6, 32'h0, 32'h0);
        EXE_MDUOp = 3'b011;
        EXE_BusA  = 32'd100;
        EXE_BusB  = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        EXE_MDUOp = 3'b000;
        chk("post_rst_hi", HI, 32'h0);
        chk("post_rst_lo", LO, 32'h0);
        mt("mtlo", 3'b110, 32'hA5A5A5A5, 1'b0, 32'h0, 32'hA5A5A5A5);
        md("mult_2_3", 3'b001, 32'd2, 32'd3, 2, 32'h0, 32'd6);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
